// File: rtl/lau_pkg.sv
// rtl/lau_pkg.sv - shared types for the chunked arithmetic units
package lau_pkg;

    typedef enum logic {
        FAST,
        SMALL
    } speed_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/sub_cz_chunk_seq_subcz.sv
// rtl/sub_cz_chunk_seq_subcz.sv - one-chunk subtractor {co,s} = a - b - ci
module sub_cz_chunk_seq_subcz
    import lau_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter speed_e      speed = FAST
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             ci,
    output logic [width-1:0] s,
    output logic             co
);

    generate
        if (speed == FAST) begin : g_fast
            assign {co, s} = {1'b0, a} - {1'b0, b} - {{width{1'b0}}, ci};
        end else begin : g_small
            logic [width-1:0] s_r;
            logic             br;

            // Bit-serial borrow chain: borrow out when a < b + borrow_in at this bit.
            always_comb begin
                s_r = '0;
                br  = ci;
                for (int i = 0; i < int'(width); i++) begin
                    s_r[i] = a[i] ^ b[i] ^ br;
                    br     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
                end
            end

            assign s  = s_r;
            assign co = br;
        end
    endgenerate

endmodule

// File: rtl/sub_cz_chunk_seq.sv
// rtl/sub_cz_chunk_seq.sv - multi-cycle wide subtract/compare, one chunk per cycle
module sub_cz_chunk_seq
    import lau_pkg::*;
#(
    parameter int unsigned width  = 8,
    parameter int unsigned chunks = 4,
    parameter speed_e      speed  = FAST
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [width*chunks-1:0]   A_i,
    input  logic [width*chunks-1:0]   B_i,
    input  logic                      CI_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [width*chunks-1:0]   S_o,
    output logic                      CO_o,
    output logic                      Z_o,
    output logic                      busy_o
);

    localparam int unsigned W  = width * chunks;
    localparam int unsigned IW = (chunks > 1) ? $clog2(chunks) : 1;

    seq_state_e      state_q, state_d;
    logic [W-1:0]    a_q, b_q, s_q;
    logic            borrow_q, zacc_q, co_q, z_q;
    logic [IW-1:0]   idx_q;
    logic [width-1:0] chunk_s;
    logic            chunk_co;
    logic [W-1:0]    s_shift;
    logic            last_chunk;
    logic            zacc_next;

    // Operands shift right each RUN cycle, so the current chunk is always the low slice.
    sub_cz_chunk_seq_subcz #(
        .width (width),
        .speed (speed)
    ) u_subcz (
        .a  (a_q[width-1:0]),
        .b  (b_q[width-1:0]),
        .ci (borrow_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Result chunks enter at the top; after all chunks chunk 0 sits at the bottom.
    generate
        if (chunks == 1) begin : g_s_one
            assign s_shift = chunk_s;
        end else begin : g_s_many
            assign s_shift = {chunk_s, s_q[W-1:width]};
        end
    endgenerate

    assign last_chunk = (idx_q == IW'(chunks - 1));
    assign zacc_next  = zacc_q & ~|chunk_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i)  state_d = RUN;
            RUN:     if (last_chunk)  state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            borrow_q <= 1'b0;
            zacc_q   <= 1'b0;
            co_q     <= 1'b0;
            z_q      <= 1'b0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q      <= A_i;
                        b_q      <= B_i;
                        borrow_q <= CI_i;
                        zacc_q   <= 1'b1;
                        idx_q    <= '0;
                    end
                end
                RUN: begin
                    s_q      <= s_shift;
                    a_q      <= a_q >> width;
                    b_q      <= b_q >> width;
                    borrow_q <= chunk_co;
                    zacc_q   <= zacc_next;
                    if (last_chunk) begin
                        co_q <= chunk_co;
                        z_q  <= zacc_next;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_o  = s_q;
    assign CO_o = co_q;
    assign Z_o  = z_q;

endmodule

// File: tb/tb_sub_cz_chunk_seq.sv
// tb/tb_sub_cz_chunk_seq.sv - directed and random checks of sub_cz_chunk_seq
module tb_sub_cz_chunk_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  iv, ordy, ci_v;
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    logic [1:0]  ir, ov, co, z, busy;
    logic [31:0] s_v [2];
    logic [7:0]  s1;
    logic [31:0] s4;

    int n_checks = 0;
    int n_fail   = 0;

    // index 0: width=8 chunks=1 (SMALL), index 1: width=8 chunks=4 (FAST)
    sub_cz_chunk_seq #(.width(8), .chunks(1), .speed(lau_pkg::SMALL)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .A_i(a_v[0][7:0]), .B_i(b_v[0][7:0]), .CI_i(ci_v[0]),
        .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
        .S_o(s1), .CO_o(co[0]), .Z_o(z[0]), .busy_o(busy[0])
    );

    sub_cz_chunk_seq #(.width(8), .chunks(4), .speed(lau_pkg::FAST)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .A_i(a_v[1]), .B_i(b_v[1]), .CI_i(ci_v[1]),
        .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
        .S_o(s4), .CO_o(co[1]), .Z_o(z[1]), .busy_o(busy[1])
    );

    assign s_v[0] = {24'h0, s1};
    assign s_v[1] = s4;

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          output logic [31:0] so, output logic coo, output logic zo,
                          output int lat);
        a_v[1] = a; b_v[1] = b; ci_v[1] = c; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0; a_v[1] = $urandom; b_v[1] = $urandom; ci_v[1] = 1'($urandom_range(0, 1));
        lat = 0;
        while (!ov[1] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        so = s_v[1]; coo = co[1]; zo = z[1];
    endtask

    task automatic release_out();
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        ordy[1] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({ir[d], ov[d], co[d], z[d], busy[d]} !== 5'b10000 || s_v[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got ir=%b ov=%b co=%b z=%b busy=%b S=%h, expected ir=1 ov=0 co=0 z=0 busy=0 S=0",
                         d, ir[d], ov[d], co[d], z[d], busy[d], s_v[d]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] so; logic coo, zo; int lat;
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, so, coo, zo, lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, expected 4", lat);
        end
        n_checks++;
        if (so !== 32'h0000_00FF || coo !== 1'b0 || zo !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got S=%h CO=%b Z=%b, expected S=000000ff CO=0 Z=0", so, coo, zo);
        end
        release_out();
        n_checks++;
        if (ir[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got ir=%b busy=%b, expected ir=1 busy=0", ir[1], busy[1]);
        end
    endtask

    task automatic test_equal();
        logic [31:0] so; logic coo, zo; int lat;
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, so, coo, zo, lat);
        n_checks++;
        if (so !== 32'h0 || coo !== 1'b0 || zo !== 1'b1) begin
            n_fail++;
            $display("FAIL equal_result: got S=%h CO=%b Z=%b, expected S=00000000 CO=0 Z=1", so, coo, zo);
        end
        release_out();
    endtask

    task automatic test_borrow_chain();
        logic [31:0] so; logic coo, zo; int lat;
        run_op(32'h0, 32'h0, 1'b1, so, coo, zo, lat);
        n_checks++;
        if (so !== 32'hFFFF_FFFF || coo !== 1'b1 || zo !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_0m0m1: got S=%h CO=%b Z=%b, expected S=ffffffff CO=1 Z=0", so, coo, zo);
        end
        release_out();
        run_op(32'h1, 32'h0, 1'b1, so, coo, zo, lat);
        n_checks++;
        if (so !== 32'h0 || coo !== 1'b0 || zo !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_1m0m1: got S=%h CO=%b Z=%b, expected S=00000000 CO=0 Z=1", so, coo, zo);
        end
        release_out();
    endtask

    task automatic test_compare();
        logic [31:0] so; logic coo, zo; int lat;
        run_op(32'h8000_0000, 32'h8000_0001, 1'b0, so, coo, zo, lat);
        n_checks++;
        if (so !== 32'hFFFF_FFFF || coo !== 1'b1 || zo !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_less: got S=%h CO=%b Z=%b, expected S=ffffffff CO=1 Z=0", so, coo, zo);
        end
        release_out();
        run_op(32'hFFFF_FFFF, 32'h0, 1'b0, so, coo, zo, lat);
        n_checks++;
        if (so !== 32'hFFFF_FFFF || coo !== 1'b0 || zo !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_max: got S=%h CO=%b Z=%b, expected S=ffffffff CO=0 Z=0", so, coo, zo);
        end
        release_out();
    endtask

    task automatic test_stall();
        logic [31:0] so; logic coo, zo; int lat;
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, so, coo, zo, lat);
        for (int i = 0; i < 3; i++) begin
            iv[1] = ~iv[1]; a_v[1] = $urandom; b_v[1] = $urandom; ci_v[1] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_checks++;
            if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || s_v[1] !== 32'h0000_00FF || co[1] !== 1'b0 || z[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got ov=%b ir=%b S=%h CO=%b Z=%b, expected ov=1 ir=0 S=000000ff CO=0 Z=0",
                         i, ov[1], ir[1], s_v[1], co[1], z[1]);
            end
        end
        iv[1] = 1'b1;
        release_out();
        iv[1] = 1'b0;
        n_checks++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got ir=%b ov=%b busy=%b, expected ir=1 ov=0 busy=0", ir[1], ov[1], busy[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] so; logic coo, zo; int lat;
        a_v[1] = 32'h1234_5678; b_v[1] = 32'h0; ci_v[1] = 1'b0; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ir[1], ov[1], co[1], z[1], busy[1]} !== 5'b10000 || s_v[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got ir=%b ov=%b co=%b z=%b busy=%b S=%h, expected ir=1 ov=0 co=0 z=0 busy=0 S=0",
                     ir[1], ov[1], co[1], z[1], busy[1], s_v[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h5, 32'h3, 1'b0, so, coo, zo, lat);
        n_checks++;
        if (so !== 32'h2 || coo !== 1'b0 || zo !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL after_reset_op: got S=%h CO=%b Z=%b lat=%0d, expected S=00000002 CO=0 Z=0 lat=4", so, coo, zo, lat);
        end
        release_out();
    endtask

    task automatic test_back_to_back(input int d, input int nops);
        logic [31:0] mask;
        logic [33:0] expq[$];
        logic [33:0] e;
        logic [32:0] full;
        logic [31:0] ms;
        int sent, got, cyc;
        logic acc;
        mask = (d == 1) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        sent = 0; got = 0; cyc = 0;
        iv[d] = 1'b0; ordy[d] = 1'b0;
        while ((sent < nops || got < nops) && cyc < 5000) begin
            if (!iv[d] && sent < nops && $urandom_range(0, 9) < 8) begin
                iv[d]   = 1'b1;
                a_v[d]  = $urandom & mask;
                b_v[d]  = ($urandom_range(0, 3) == 0) ? a_v[d] : ($urandom & mask);
                ci_v[d] = 1'($urandom_range(0, 1));
            end
            ordy[d] = ($urandom_range(0, 9) < 6);
            if (ov[d] && ordy[d]) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_spurious: got S=%h with no pending op, expected no result", d, s_v[d]);
                end else begin
                    e = expq.pop_front();
                    if ({co[d], z[d], s_v[d]} !== e) begin
                        n_fail++;
                        $display("FAIL rand%0d_result: got CO=%b Z=%b S=%h, expected CO=%b Z=%b S=%h",
                                 d, co[d], z[d], s_v[d], e[33], e[32], e[31:0]);
                    end
                end
                got++;
            end
            acc = iv[d] & ir[d];
            if (acc) begin
                full = {1'b0, a_v[d]} - {1'b0, b_v[d]} - {32'h0, ci_v[d]};
                ms   = full[31:0] & mask;
                expq.push_back({full[32], (ms == 32'h0), ms});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) iv[d] = 1'b0;
        end
        iv[d] = 1'b0; ordy[d] = 1'b0;
        n_checks++;
        if (got != nops) begin
            n_fail++;
            $display("FAIL rand%0d_count: got %0d results, expected %0d", d, got, nops);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv = '0; ordy = '0; ci_v = '0;
        a_v[0] = '0; a_v[1] = '0; b_v[0] = '0; b_v[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_equal();
        test_borrow_chain();
        test_compare();
        test_stall();
        test_reset_mid_run();
        test_back_to_back(1, 60);
        test_back_to_back(0, 80);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
